// File: rtl/nor_flash_responder_if.sv
// Parallel NOR bus between the flash controller (master) and a flash device (slave).
// Signal names follow the device-side pin naming so both ends read the same.
interface nor_flash_responder_if #(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16
);
  logic                nor_ce_i;
  logic                nor_we_i;
  logic                nor_oe_i;
  logic [ADDRBITS-1:0] nor_addr_i;
  logic [DATABITS-1:0] nor_data_i;
  logic [DATABITS-1:0] nor_data_o;
  logic                nor_data_oe;
  logic                nor_ry_o;

  modport master (
    output nor_ce_i, nor_we_i, nor_oe_i, nor_addr_i, nor_data_i,
    input  nor_data_o, nor_data_oe, nor_ry_o
  );

  modport slave (
    input  nor_ce_i, nor_we_i, nor_oe_i, nor_addr_i, nor_data_i,
    output nor_data_o, nor_data_oe, nor_ry_o
  );
endinterface

// File: rtl/nor_flash_responder.sv
// NOR flash target: small word array, AA/55/A0 word program, F0 reset,
// latency-timed reads and a busy status word with toggle bit.
module nor_flash_responder #(
  parameter int ADDRBITS     = 26,
  parameter int DATABITS     = 16,
  parameter int MEMBITS      = 10,
  parameter int READ_LATENCY = 4,
  parameter int PROG_CYCLES  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  nor_flash_responder_if.slave  bus
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int PRG_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic [PRG_W-1:0] PRG_LAST = PRG_W'(PROG_CYCLES - 1);

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_UNLOCK1,
    CMD_UNLOCK2,
    CMD_PROG,
    CMD_BUSY
  } cmd_state_t;

  logic                ce_q;
  logic                we_q;
  logic                oe_q;
  logic [ADDRBITS-1:0] addr_q;
  logic [DATABITS-1:0] data_q;

  // Array is stored complemented so the power-up all-zero state reads as erased.
  logic [DATABITS-1:0] mem_n [0:(1<<MEMBITS)-1];
  logic [MEMBITS-1:0]  pend_addr;
  logic [DATABITS-1:0] pend_data;

  cmd_state_t          state;
  logic [PRG_W-1:0]    prog_cnt;
  logic                ry_r;

  logic [LAT_W-1:0]    lat_cnt;
  logic                data_oe_r;
  logic [DATABITS-1:0] data_o_r;
  logic                tgl;
  logic                stat_tgl;

  logic                wr_evt;
  logic                cmd_f0;
  logic                rd_act;
  logic                rd_act_q;
  logic                rd_start;
  logic                rd_restart;
  logic                busy;
  logic                prog_latch;
  logic                prog_done;
  logic [DATABITS-1:0] rd_word;

  assign wr_evt     = ~ce_q & ~we_q & bus.nor_we_i;
  assign cmd_f0     = (data_q[7:0] == 8'hF0);
  assign rd_act     = ~bus.nor_ce_i & ~bus.nor_oe_i & bus.nor_we_i;
  assign rd_act_q   = ~ce_q & ~oe_q & we_q;
  assign rd_start   = rd_act & ~rd_act_q;
  assign rd_restart = rd_start | (rd_act & (bus.nor_addr_i != addr_q));
  assign busy       = (state == CMD_BUSY);
  assign prog_latch = wr_evt & ~cmd_f0 & (state == CMD_PROG);
  assign prog_done  = busy & (prog_cnt == PRG_LAST);

  always_comb begin
    rd_word = '0;
    if (busy) begin
      rd_word[7] = ~pend_data[7];
      rd_word[6] = stat_tgl;
    end else begin
      rd_word = ~mem_n[bus.nor_addr_i[MEMBITS-1:0]];
    end
  end

  // Input sampling stage: control strobes reset to inactive, data path free-running.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ce_q <= 1'b1;
      we_q <= 1'b1;
      oe_q <= 1'b1;
    end else begin
      ce_q <= bus.nor_ce_i;
      we_q <= bus.nor_we_i;
      oe_q <= bus.nor_oe_i;
    end
  end

  always_ff @(posedge clk_i) begin
    addr_q <= bus.nor_addr_i;
    data_q <= bus.nor_data_i;
    if (prog_latch) begin
      pend_addr <= addr_q[MEMBITS-1:0];
      pend_data <= data_q;
    end
    if (prog_done) begin
      mem_n[pend_addr] <= mem_n[pend_addr] | ~pend_data;
    end
  end

  // Command stage: unlock sequence decode and program timer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= CMD_IDLE;
      prog_cnt <= '0;
      ry_r     <= 1'b1;
    end else begin
      case (state)
        CMD_BUSY: begin
          if (prog_done) begin
            ry_r  <= 1'b1;
            state <= CMD_IDLE;
          end else begin
            prog_cnt <= prog_cnt + 1'b1;
          end
        end
        default: begin
          if (wr_evt) begin
            if (cmd_f0) begin
              state <= CMD_IDLE;
            end else begin
              case (state)
                CMD_IDLE: begin
                  if (data_q[7:0] == 8'hAA && addr_q[11:0] == 12'h555) state <= CMD_UNLOCK1;
                end
                CMD_UNLOCK1: begin
                  state <= (data_q[7:0] == 8'h55 && addr_q[11:0] == 12'h2AA) ? CMD_UNLOCK2 : CMD_IDLE;
                end
                CMD_UNLOCK2: begin
                  state <= (data_q[7:0] == 8'hA0 && addr_q[11:0] == 12'h555) ? CMD_PROG : CMD_IDLE;
                end
                CMD_PROG: begin
                  state    <= CMD_BUSY;
                  prog_cnt <= '0;
                  ry_r     <= 1'b0;
                end
                default: state <= CMD_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  // Read stage: latency timer restarts on access start or address change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_cnt   <= '0;
      data_oe_r <= 1'b0;
      data_o_r  <= '0;
      tgl       <= 1'b0;
      stat_tgl  <= 1'b0;
    end else begin
      if (rd_act) begin
        if (rd_restart) begin
          lat_cnt   <= '0;
          data_oe_r <= 1'b0;
        end else if (lat_cnt == LAT_LAST) begin
          data_oe_r <= 1'b1;
          data_o_r  <= rd_word;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end else begin
        data_oe_r <= 1'b0;
      end
      // Each busy read reports the toggle state at its start, then flips it for the next poll.
      if (rd_start && busy) begin
        stat_tgl <= tgl;
        tgl      <= ~tgl;
      end
    end
  end

  assign bus.nor_data_o  = data_o_r;
  assign bus.nor_data_oe = data_oe_r;
  assign bus.nor_ry_o    = ry_r;

endmodule

// File: tb/tb_nor_flash_responder.sv
// Directed and randomized checks of nor_flash_responder against a word-level flash model.
module tb_nor_flash_responder;
  localparam int ADDRBITS = 26;
  localparam int DATABITS = 16;
  localparam int MEMBITS  = 10;
  localparam int RL       = 4;
  localparam int PC       = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  nor_flash_responder_if #(.ADDRBITS(ADDRBITS), .DATABITS(DATABITS)) bus ();

  nor_flash_responder #(
    .ADDRBITS(ADDRBITS), .DATABITS(DATABITS), .MEMBITS(MEMBITS),
    .READ_LATENCY(RL), .PROG_CYCLES(PC)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: word array, unlock progress, busy flag and toggle state.
  logic [15:0] m_mem [1024];
  int          m_seq;
  bit          m_busy;
  bit          m_tgl;
  logic [15:0] m_pend;
  logic [11:0] seq_a [3];
  logic [7:0]  seq_d [3];

  // Busy-pulse monitor: length of each completed RY-BY# low run.
  int run_len = 0;
  int last_run = 0;
  int n_runs = 0;
  always @(negedge clk_i) begin
    if (bus.nor_ry_o === 1'b0) run_len <= run_len + 1;
    else if (run_len != 0) begin
      last_run <= run_len;
      n_runs   <= n_runs + 1;
      run_len  <= 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_write(input logic [ADDRBITS-1:0] a, input logic [15:0] d, output bit started);
    started = 1'b0;
    if (!m_busy) begin
      if (d[7:0] == 8'hF0) m_seq = 0;
      else if (m_seq == 3) begin
        started = 1'b1;
        m_seq = 0;
      end else if (a[11:0] == seq_a[m_seq] && d[7:0] == seq_d[m_seq]) m_seq++;
      else m_seq = 0;
    end
  endtask

  task automatic bus_write(input logic [ADDRBITS-1:0] a, input logic [15:0] d, output bit started);
    bus.nor_addr_i = a;
    bus.nor_data_i = d;
    bus.nor_oe_i   = 1'b1;
    bus.nor_ce_i   = 1'b0;
    bus.nor_we_i   = 1'b0;
    step();
    bus.nor_ce_i   = 1'b1;
    bus.nor_we_i   = 1'b1;
    step();
    model_write(a, d, started);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < PC * 4 && bus.nor_ry_o !== 1'b1; i++) step();
    check(tag, {31'b0, bus.nor_ry_o}, 32'd1);
    step();
    m_busy = 1'b0;
  endtask

  task automatic read_check(input logic [ADDRBITS-1:0] a, input logic [15:0] exp, input string tag);
    bus.nor_addr_i = a;
    bus.nor_we_i   = 1'b1;
    bus.nor_ce_i   = 1'b0;
    bus.nor_oe_i   = 1'b0;
    for (int i = 0; i < RL; i++) step();
    check({tag, "_oe_early"}, {31'b0, bus.nor_data_oe}, 32'd0);
    step();
    check({tag, "_oe"}, {31'b0, bus.nor_data_oe}, 32'd1);
    check({tag, "_data"}, {16'b0, bus.nor_data_o}, {16'b0, exp});
    bus.nor_ce_i = 1'b1;
    bus.nor_oe_i = 1'b1;
    step();
    check({tag, "_oe_off"}, {31'b0, bus.nor_data_oe}, 32'd0);
    check({tag, "_hold"}, {16'b0, bus.nor_data_o}, {16'b0, exp});
  endtask

  function automatic logic [15:0] status_word();
    logic [15:0] s = 16'h0000;
    s[7] = ~m_pend[7];
    s[6] = m_tgl;
    return s;
  endfunction

  task automatic read_model(input logic [ADDRBITS-1:0] a, input string tag);
    logic [15:0] exp;
    if (m_busy) begin
      exp = status_word();
      m_tgl = ~m_tgl;
    end else begin
      exp = m_mem[a[MEMBITS-1:0]];
    end
    read_check(a, exp, tag);
  endtask

  task automatic unlock3();
    bit s;
    bus_write(ADDRBITS'(12'h555), 16'h00AA, s);
    bus_write(ADDRBITS'(12'h2AA), 16'h0055, s);
    bus_write(ADDRBITS'(12'h555), 16'h00A0, s);
  endtask

  task automatic prog_word(input logic [ADDRBITS-1:0] a, input logic [15:0] d, input bit poke);
    bit s;
    bit s2;
    int runs0;
    runs0 = n_runs;
    unlock3();
    bus_write(a, d, s);
    if (s) begin
      m_busy = 1'b1;
      m_pend = d;
      check("prog_ry_low", {31'b0, bus.nor_ry_o}, 32'd0);
      if (poke) begin
        bus_write(a, 16'h00F0, s2);
        bus_write(ADDRBITS'(12'h555), 16'h00AA, s2);
      end
      wait_ready("prog_ry_return");
      check("prog_busy_len", last_run, PC);
      check("prog_runs", n_runs, runs0 + 1);
      m_mem[a[MEMBITS-1:0]] &= d;
    end else begin
      repeat (PC + 2) step();
      check("noprog_runs", n_runs, runs0);
      check("noprog_ry", {31'b0, bus.nor_ry_o}, 32'd1);
    end
  endtask

  initial begin
    bit s;
    int runs0;
    logic [15:0] d;
    logic [15:0] exp;
    logic [ADDRBITS-1:0] a;
    logic [ADDRBITS-1:0] hi_mask;

    for (int i = 0; i < 1024; i++) m_mem[i] = 16'hFFFF;
    seq_a = '{12'h555, 12'h2AA, 12'h555};
    seq_d = '{8'hAA, 8'h55, 8'hA0};
    m_seq = 0; m_busy = 1'b0; m_tgl = 1'b0; m_pend = 16'h0;
    hi_mask = ~ADDRBITS'((1 << MEMBITS) - 1);
    bus.nor_ce_i = 1'b1; bus.nor_we_i = 1'b1; bus.nor_oe_i = 1'b1;
    bus.nor_addr_i = '0; bus.nor_data_i = '0;

    // Reset state
    rst_i = 1'b1;
    repeat (3) step();
    check("rst_ry", {31'b0, bus.nor_ry_o}, 32'd1);
    check("rst_oe", {31'b0, bus.nor_data_oe}, 32'd0);
    check("rst_data", {16'b0, bus.nor_data_o}, 32'd0);
    rst_i = 1'b0;
    step();

    // Erased read with exact latency
    read_model(ADDRBITS'(24'h000123), "erased");

    // Program 0x1234@0x040 with two status polls while busy
    runs0 = n_runs;
    unlock3();
    bus_write(ADDRBITS'(24'h000040), 16'h1234, s);
    m_busy = s;
    m_pend = 16'h1234;
    check("p1_ry_low", {31'b0, bus.nor_ry_o}, 32'd0);
    read_model(ADDRBITS'(12'h040), "busy_rd1");
    read_model(ADDRBITS'(12'h040), "busy_rd2");
    wait_ready("p1_ry_return");
    check("p1_busy_len", last_run, PC);
    check("p1_runs", n_runs, runs0 + 1);
    m_mem[10'h040] &= 16'h1234;
    read_model(ADDRBITS'(12'h040), "p1_word");

    // AND semantics and address aliasing
    prog_word(ADDRBITS'(12'h040), 16'hFF00, 1'b0);
    read_model(ADDRBITS'(12'h040), "and_word");
    prog_word(ADDRBITS'(12'h400), 16'hABCD, 1'b0);
    read_model(ADDRBITS'(12'h000), "alias_0");
    read_model(ADDRBITS'(12'h400), "alias_400");

    // Broken unlock sequences must not program
    runs0 = n_runs;
    bus_write(ADDRBITS'(12'h555), 16'h00AA, s);
    bus_write(ADDRBITS'(12'h2AA), 16'h0056, s);
    bus_write(ADDRBITS'(12'h555), 16'h00A0, s);
    bus_write(ADDRBITS'(12'h010), 16'h0000, s);
    repeat (PC + 2) step();
    check("broken1_runs", n_runs, runs0);
    read_model(ADDRBITS'(12'h010), "broken1_word");
    bus_write(ADDRBITS'(12'h555), 16'h00AA, s);
    bus_write(ADDRBITS'(12'h123), 16'h00F0, s);
    bus_write(ADDRBITS'(12'h2AA), 16'h0055, s);
    bus_write(ADDRBITS'(12'h555), 16'h00A0, s);
    bus_write(ADDRBITS'(12'h010), 16'h0000, s);
    repeat (PC + 2) step();
    check("broken2_runs", n_runs, runs0);
    read_model(ADDRBITS'(12'h010), "broken2_word");

    // Reset five cycles into a program while a status read is driving
    unlock3();
    bus_write(ADDRBITS'(12'h020), 16'h0F0F, s);
    m_busy = s;
    m_pend = 16'h0F0F;
    check("rb_ry_low", {31'b0, bus.nor_ry_o}, 32'd0);
    exp = status_word();
    m_tgl = ~m_tgl;
    bus.nor_addr_i = ADDRBITS'(12'h020);
    bus.nor_ce_i = 1'b0;
    bus.nor_oe_i = 1'b0;
    repeat (RL + 1) step();
    check("rb_stat_oe", {31'b0, bus.nor_data_oe}, 32'd1);
    check("rb_stat", {16'b0, bus.nor_data_o}, {16'b0, exp});
    rst_i = 1'b1;
    #1;
    check("rb_ry_now", {31'b0, bus.nor_ry_o}, 32'd1);
    check("rb_oe_now", {31'b0, bus.nor_data_oe}, 32'd0);
    check("rb_data_now", {16'b0, bus.nor_data_o}, 32'd0);
    bus.nor_ce_i = 1'b1;
    bus.nor_oe_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    m_busy = 1'b0; m_seq = 0; m_tgl = 1'b0;
    step(); step();
    read_model(ADDRBITS'(12'h020), "rb_target");
    prog_word(ADDRBITS'(12'h020), 16'h0F0F, 1'b0);
    read_model(ADDRBITS'(12'h020), "rb_reprog");

    // Address change two cycles into a read
    d = 16'($urandom) & 16'h7FFF;
    if (d[7:0] == 8'hF0) d[7:0] = 8'h0F;
    prog_word(ADDRBITS'(12'h011), d, 1'b0);
    bus.nor_addr_i = ADDRBITS'(12'h010);
    bus.nor_we_i = 1'b1;
    bus.nor_ce_i = 1'b0;
    bus.nor_oe_i = 1'b0;
    step(); step();
    bus.nor_addr_i = ADDRBITS'(12'h011);
    for (int i = 0; i < RL; i++) begin
      step();
      check("achg_oe_low", {31'b0, bus.nor_data_oe}, 32'd0);
    end
    step();
    check("achg_oe", {31'b0, bus.nor_data_oe}, 32'd1);
    check("achg_data", {16'b0, bus.nor_data_o}, {16'b0, m_mem[10'h011]});
    bus.nor_ce_i = 1'b1;
    bus.nor_oe_i = 1'b1;
    step();

    // Randomized programs, busy-time pokes and aliased reads
    for (int it = 0; it < 8; it++) begin
      a = ADDRBITS'($urandom);
      d = 16'($urandom);
      prog_word(a, d, it[0]);
      read_model(a ^ (ADDRBITS'($urandom) & hi_mask), "rnd_alias");
      read_model(ADDRBITS'($urandom), "rnd_other");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
